// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_state_e     - sequencer states (IDLE, REQ, WAIT, DRAIN, OUT)
//   NOP_INSTR         - instruction word presented to decode out of reset
//   DEFAULT_*_VECTOR  - default reset and misaligned-redirect trap targets
//   is_misaligned()   - true when an address is not word aligned
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_plus_4.sv
// pc_plus_4: next sequential program counter.
//   current_pc in  32  current PC
//   next_pc    out 32  current_pc + 4, wrapping modulo 2^32
module pc_plus_4 (
    input  logic [31:0] current_pc,
    output logic [31:0] next_pc
);

    // Natural 32-bit wrap gives 0xFFFF_FFFC -> 0x0000_0000.
    assign next_pc = current_pc + 32'd4;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, issues one outstanding
// valid/ready request to instruction memory, presents the fetched word to
// decode, and drops responses made stale by a redirect.
//
// Ports:
//   clk, reset (async, active low)
//   imem_req_valid/ready/addr  - fetch request (addr always equals pc)
//   imem_rsp_valid/data        - fetch response (one-cycle pulse)
//   redirect_valid/pc          - branch/jump/trap redirect (one-cycle pulse)
//   stall                      - decode cannot accept this cycle
//   if_valid/if_pc/if_instr    - instruction handed to decode
//   fetch_fault                - pulse after a misaligned redirect
//
// Build option: FETCH_ALIGN_CHECK_EN - when defined, a misaligned redirect
// target loads TRAP_VECTOR and pulses fetch_fault; when undefined the target is
// truncated to a word address and fetch_fault stays 0.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic         fault_q, fault_d;

    logic [31:0]  pc_inc_s;
    logic [31:0]  target_s;
    logic         target_fault_s;

    pc_plus_4 u_pc_plus_4 (
        .current_pc (pc_q),
        .next_pc    (pc_inc_s)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect targets trap instead of being fetched.
    always_comb begin
        if (is_misaligned(redirect_pc)) begin
            target_s       = TRAP_VECTOR;
            target_fault_s = 1'b1;
        end else begin
            target_s       = redirect_pc;
            target_fault_s = 1'b0;
        end
    end
`else
    logic unused_align_s;
    assign target_s       = {redirect_pc[31:2], 2'b00};
    assign target_fault_s = 1'b0;
    assign unused_align_s = ^{TRAP_VECTOR, redirect_pc[1:0]};
`endif

    // Next-state logic; a redirect overrides stall and any response.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        fault_d    = 1'b0;
        if (redirect_valid) begin
            pc_d       = target_s;
            fault_d    = target_fault_s;
            if_valid_d = 1'b0;
            case (state_q)
                // A response arriving with the redirect is simply dropped;
                // without one, the outstanding response must be drained.
                ST_WAIT:  state_d = imem_rsp_valid ? ST_IDLE : ST_DRAIN;
                ST_DRAIN: state_d = ST_DRAIN;
                default:  state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (imem_req_ready) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_d    = ST_OUT;
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = imem_rsp_data;
                        pc_d       = pc_inc_s;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    // Stale response: consume it without updating outputs.
                    if (imem_rsp_valid) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_OUT: begin
                    if (!stall) begin
                        state_d    = ST_REQ;
                        if_valid_d = 1'b0;
                    end else begin
                        state_d = ST_OUT;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    if_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0000_0000;
            if_instr_q <= NOP_INSTR;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            fault_q    <= fault_d;
        end
    end

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;
    assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios followed by a randomized run checked
// against a delivery-order model of the fetch stream and a single-outstanding
// memory model. A second instance with RESET_VECTOR=0xFFFF_FFFC shares the
// stimulus to exercise PC wrap out of reset.
module tb_fetch_ctrl;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif
    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;

    logic        req_valid, if_valid, fault;
    logic [31:0] req_addr, if_pc, if_instr;
    logic        req_valid_w, if_valid_w, fault_w;
    logic [31:0] req_addr_w, if_pc_w, if_instr_w;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_ctrl dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .fetch_fault(fault)
    );

    fetch_ctrl #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req_valid(req_valid_w), .imem_req_ready(req_ready), .imem_req_addr(req_addr_w),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .if_valid(if_valid_w), .if_pc(if_pc_w), .if_instr(if_instr_w), .fetch_fault(fault_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: odd-constant multiply keeps every word address distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_valid"}, {31'd0, req_valid}, 32'd0);
        chk({tag, "_req_addr"},  req_addr, 32'h0000_0000);
        chk({tag, "_if_valid"},  {31'd0, if_valid}, 32'd0);
        chk({tag, "_if_pc"},     if_pc, 32'h0000_0000);
        chk({tag, "_if_instr"},  if_instr, 32'h0000_0013);
        chk({tag, "_fault"},     {31'd0, fault}, 32'd0);
    endtask

    logic [31:0] exp_pc, pend_addr, tgt, rpc;
    logic        pend, exp_fault, redir, mis;
    int          cnt, deliveries;

    initial begin
        reset = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; stall = 1'b0;
        #12;
        chk_reset_state("rst");
        chk("rst_w_addr", req_addr_w, 32'hFFFF_FFFC);

        // Basic fetch: accept immediately, respond one cycle later.
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("f1_req_valid", {31'd0, req_valid}, 32'd1);
        chk("f1_req_addr", req_addr, 32'h0000_0000);
        chk("w_first_addr", req_addr_w, 32'hFFFF_FFFC);
        req_ready = 1'b1;
        @(negedge clk);
        chk("f1_wait_req_valid", {31'd0, req_valid}, 32'd0);
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0050_0093;
        @(negedge clk);
        chk("f1_if_valid", {31'd0, if_valid}, 32'd1);
        chk("f1_if_pc", if_pc, 32'h0000_0000);
        chk("f1_if_instr", if_instr, 32'h0050_0093);
        chk("w_if_pc", if_pc_w, 32'hFFFF_FFFC);
        rsp_valid = 1'b0; rsp_data = 32'd0; stall = 1'b1;

        // Stall holds the output for three cycles with no new request.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_if_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_if_pc", if_pc, 32'h0000_0000);
            chk("stall_if_instr", if_instr, 32'h0050_0093);
            chk("stall_no_req", {31'd0, req_valid}, 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("f2_if_valid", {31'd0, if_valid}, 32'd0);
        chk("f2_req_valid", {31'd0, req_valid}, 32'd1);
        chk("f2_req_addr", req_addr, 32'h0000_0004);
        chk("w_wrap_addr", req_addr_w, 32'h0000_0000);
        req_ready = 1'b1;

        // Redirect in WAIT: the next response is stale and must be dropped.
        @(negedge clk);
        req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        chk("drain_req_valid", {31'd0, req_valid}, 32'd0);
        redirect_valid = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("drain_if_valid", {31'd0, if_valid}, 32'd0);
        chk("drain_if_instr", if_instr, 32'h0050_0093);
        chk("drain_req_valid2", {31'd0, req_valid}, 32'd1);
        chk("drain_req_addr", req_addr, 32'h0000_0200);
        req_ready = 1'b1;

        // Redirect coinciding with a response: response dropped.
        @(negedge clk);
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hCAFE_0001;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        @(negedge clk);
        rsp_valid = 1'b0; redirect_valid = 1'b0;
        chk("same_if_valid", {31'd0, if_valid}, 32'd0);
        chk("same_req_valid", {31'd0, req_valid}, 32'd0);
        @(negedge clk);
        chk("same_req_valid2", {31'd0, req_valid}, 32'd1);
        chk("same_req_addr", req_addr, 32'h0000_0300);

        // Misaligned redirect from REQ.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("mis_fault", {31'd0, fault}, ALIGN_EN ? 32'd1 : 32'd0);
        chk("mis_req_valid", {31'd0, req_valid}, 32'd0);
        @(negedge clk);
        chk("mis_fault_end", {31'd0, fault}, 32'd0);
        chk("mis_req_addr", req_addr, ALIGN_EN ? TRAP : 32'h0000_0200);

        // PC wrap through a redirect to the last word.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap_req_addr", req_addr, 32'hFFFF_FFFC);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0000_0073;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_if_instr", if_instr, 32'h0000_0073);
        @(negedge clk);
        chk("wrap_next_addr", req_addr, 32'h0000_0000);
        req_ready = 1'b1;

        // Reset mid-transaction returns to the reset state at once.
        @(negedge clk);
        req_ready = 1'b0;
        #2 reset = 1'b0;
        #1 chk_reset_state("midrst");
        @(negedge clk);
        reset = 1'b1;

        // Randomized run against the delivery-order model.
        exp_pc = 32'h0000_0000; pend = 1'b0; cnt = 0; pend_addr = 32'd0;
        exp_fault = 1'b0; deliveries = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (req_valid) chk("rnd_req_addr", req_addr, exp_pc);
            if (if_valid) begin
                chk("rnd_if_pc", if_pc, exp_pc);
                chk("rnd_if_instr", if_instr, mem_word(exp_pc));
            end
            chk("rnd_fault", {31'd0, fault}, {31'd0, exp_fault});

            stall     = ($urandom_range(0, 2) == 0);
            req_ready = ($urandom_range(0, 3) != 0);
            rsp_valid = pend && (cnt == 0);
            rsp_data  = rsp_valid ? mem_word(pend_addr) : $urandom;
            // Redirect never collides with an accept or a response.
            redir = ($urandom_range(0, 24) == 0) && !(req_valid && req_ready) && !rsp_valid;
            rpc   = $urandom & 32'h0000_0FFF;
            tgt   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | (rpc & 32'h0000_000F)) : rpc;
            redirect_valid = redir;
            redirect_pc    = tgt;

            if (rsp_valid) pend = 1'b0;
            else if (pend) cnt--;
            if (req_valid && req_ready && !redir) begin
                pend = 1'b1; cnt = $urandom_range(0, 2); pend_addr = exp_pc;
            end
            mis       = (tgt[1:0] != 2'b00);
            exp_fault = redir && ALIGN_EN && mis;
            if (redir) begin
                exp_pc = (ALIGN_EN && mis) ? TRAP : {tgt[31:2], 2'b00};
            end else if (if_valid && !stall) begin
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
        end
        chk("rnd_progress", (deliveries > 100) ? 32'd1 : 32'd0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
